// File: rtl/mem_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_pkg
// Description : Shared definitions for the MEM/WB pipeline register slice:
//               stall vector bit positions, the NOP register address, the
//               zero word and the lane write-request record.
//               Optional feature macro used by this slice: MEM_WB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_wb_pkg;

    // Default datapath widths of the multi-issue core.
    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    // Positions inside the 6-bit pipeline stall vector.
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    // Register 0 is hard-wired; a write to it is a NOP.
    localparam logic [WB_ADDR_W-1:0] NOP_REG_ADDR = '0;
    localparam logic [WB_DATA_W-1:0] ZERO_WORD    = '0;

    // One register-file write request as it travels down a lane.
    typedef struct packed {
        logic [WB_DATA_W-1:0] wdata;
        logic [WB_ADDR_W-1:0] wd;
        logic                 wreg;
        logic                 valid;
    } wr_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_wr_filter.sv
`default_nettype none
// ============================================================================
// Module      : wb_wr_filter
// Description : Combinational lane write filter. Drops writes to register 0
//               and collapses same-destination writes so that only the
//               youngest lane (highest index) keeps its write enable.
// Ports       : i_valid  [LANES]         lane carries a live instruction
//               i_wd     [LANES*ADDR_W]  lane destination register
//               i_wreg   [LANES]         lane write enable (raw)
//               o_wreg   [LANES]         lane write enable (filtered)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_wr_filter
    import mem_wb_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int LANES  = 2
) (
    input  logic [LANES-1:0]        i_valid,
    input  logic [LANES*ADDR_W-1:0] i_wd,
    input  logic [LANES-1:0]        i_wreg,
    output logic [LANES-1:0]        o_wreg
);

    logic [LANES-1:0]  w_req;
    logic [ADDR_W-1:0] w_wd [LANES];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_unpack
            assign w_wd[gi]  = i_wd[gi*ADDR_W +: ADDR_W];
            assign w_req[gi] = i_valid[gi] & i_wreg[gi];
        end

        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic w_keep;

            // A lane survives only if no younger live writer targets the
            // same register; the youngest lane has nothing younger to lose to.
            always_comb begin
                w_keep = w_req[gi] && (w_wd[gi] != ADDR_W'(NOP_REG_ADDR));
                for (int j = gi + 1; j < LANES; j++) begin
                    if (w_req[j] && (w_wd[j] == w_wd[gi])) begin
                        w_keep = 1'b0;
                    end
                end
            end

            assign o_wreg[gi] = w_keep;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_wb_mlane.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_mlane
// Description : Multi-lane MEM/WB pipeline register. Captures up to LANES
//               register-file writes plus one HI/LO write and presents them
//               to WB one cycle later. Supports flush, bubble and hold via
//               the stall vector, and filters register-0 / shadowed writes.
//               Optional: MEM_WB_PERF_EN adds saturating bubble/hold counters
//               (parameter CNT_W, ports bubble_cnt / hold_cnt).
// Ports       : clk, rst (async, active-low), stall[5:0], flush,
//               mem_valid/mem_wdata/mem_wd/mem_wreg (per lane),
//               mem_whilo/mem_hi/mem_lo, and the registered wb_* outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_mlane
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 2
`ifdef MEM_WB_PERF_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic                    flush,
    input  logic [LANES-1:0]        mem_valid,
    input  logic [LANES*DATA_W-1:0] mem_wdata,
    input  logic [LANES*ADDR_W-1:0] mem_wd,
    input  logic [LANES-1:0]        mem_wreg,
    input  logic                    mem_whilo,
    input  logic [DATA_W-1:0]       mem_hi,
    input  logic [DATA_W-1:0]       mem_lo,
    output logic [LANES-1:0]        wb_valid,
    output logic [LANES*DATA_W-1:0] wb_wdata,
    output logic [LANES*ADDR_W-1:0] wb_wd,
    output logic [LANES-1:0]        wb_wreg,
    output logic                    wb_whilo,
    output logic [DATA_W-1:0]       wb_hi,
    output logic [DATA_W-1:0]       wb_lo
`ifdef MEM_WB_PERF_EN
    ,
    output logic [CNT_W-1:0]        bubble_cnt,
    output logic [CNT_W-1:0]        hold_cnt
`endif
);

    logic [LANES-1:0]        w_wreg_filt;
    logic                    w_bubble;
    logic                    w_load;
    logic                    w_unused_stall;

    logic [LANES-1:0]        r_valid;
    logic [LANES*DATA_W-1:0] r_wdata;
    logic [LANES*ADDR_W-1:0] r_wd;
    logic [LANES-1:0]        r_wreg;
    logic                    r_whilo;
    logic [DATA_W-1:0]       r_hi;
    logic [DATA_W-1:0]       r_lo;

    // Only the MEM and WB stall bits matter to this register.
    assign w_unused_stall = ^stall[3:0];

    // Flush beats everything; a stalled MEM feeding a running WB inserts a
    // bubble; MEM and WB both stalled leaves the register untouched.
    assign w_bubble = flush | (stall[STALL_MEM] & ~stall[STALL_WB]);
    assign w_load   = ~flush & ~stall[STALL_MEM];

    wb_wr_filter #(
        .ADDR_W (ADDR_W),
        .LANES  (LANES)
    ) u_wr_filter (
        .i_valid (mem_valid),
        .i_wd    (mem_wd),
        .i_wreg  (mem_wreg),
        .o_wreg  (w_wreg_filt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_wdata <= '0;
            r_wd    <= '0;
            r_wreg  <= '0;
            r_whilo <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (w_bubble) begin
            r_valid <= '0;
            r_wdata <= '0;
            r_wd    <= '0;
            r_wreg  <= '0;
            r_whilo <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (w_load) begin
            r_valid <= mem_valid;
            r_wdata <= mem_wdata;
            r_wd    <= mem_wd;
            r_wreg  <= w_wreg_filt;
            r_whilo <= mem_whilo;
            r_hi    <= mem_hi;
            r_lo    <= mem_lo;
        end
    end

    assign wb_valid = r_valid;
    assign wb_wdata = r_wdata;
    assign wb_wd    = r_wd;
    assign wb_wreg  = r_wreg;
    assign wb_whilo = r_whilo;
    assign wb_hi    = r_hi;
    assign wb_lo    = r_lo;

`ifdef MEM_WB_PERF_EN
    logic             w_hold;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_hold_cnt;

    assign w_hold = ~flush & stall[STALL_MEM] & stall[STALL_WB];

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
            r_hold_cnt   <= '0;
        end else begin
            if (w_bubble && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
            if (w_hold && (r_hold_cnt != '1)) begin
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign hold_cnt   = r_hold_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_mlane.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_mlane
// Description : Self-checking bench for mem_wb_mlane (LANES=2). Directed
//               scenarios followed by randomized traffic, all compared
//               against a behavioural model. With MEM_WB_PERF_EN defined the
//               counters are built with CNT_W=2 and checked as well.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_mlane;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int LANES  = 2;

    logic                    clk;
    logic                    rst;
    logic [5:0]              stall;
    logic                    flush;
    logic [LANES-1:0]        mem_valid;
    logic [LANES*DATA_W-1:0] mem_wdata;
    logic [LANES*ADDR_W-1:0] mem_wd;
    logic [LANES-1:0]        mem_wreg;
    logic                    mem_whilo;
    logic [DATA_W-1:0]       mem_hi;
    logic [DATA_W-1:0]       mem_lo;
    logic [LANES-1:0]        wb_valid;
    logic [LANES*DATA_W-1:0] wb_wdata;
    logic [LANES*ADDR_W-1:0] wb_wd;
    logic [LANES-1:0]        wb_wreg;
    logic                    wb_whilo;
    logic [DATA_W-1:0]       wb_hi;
    logic [DATA_W-1:0]       wb_lo;
`ifdef MEM_WB_PERF_EN
    logic [1:0]              bubble_cnt;
    logic [1:0]              hold_cnt;
`endif

    // Expected-state model.
    logic [LANES-1:0]        e_valid;
    logic [LANES*DATA_W-1:0] e_wdata;
    logic [LANES*ADDR_W-1:0] e_wd;
    logic [LANES-1:0]        e_wreg;
    logic                    e_whilo;
    logic [DATA_W-1:0]       e_hi;
    logic [DATA_W-1:0]       e_lo;
    int                      e_bub;
    int                      e_hold;

    int n_chk;
    int n_pass;

    mem_wb_mlane #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LANES  (LANES)
`ifdef MEM_WB_PERF_EN
        ,
        .CNT_W  (2)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .mem_valid  (mem_valid),
        .mem_wdata  (mem_wdata),
        .mem_wd     (mem_wd),
        .mem_wreg   (mem_wreg),
        .mem_whilo  (mem_whilo),
        .mem_hi     (mem_hi),
        .mem_lo     (mem_lo),
        .wb_valid   (wb_valid),
        .wb_wdata   (wb_wdata),
        .wb_wd      (wb_wd),
        .wb_wreg    (wb_wreg),
        .wb_whilo   (wb_whilo),
        .wb_hi      (wb_hi),
        .wb_lo      (wb_lo)
`ifdef MEM_WB_PERF_EN
        ,
        .bubble_cnt (bubble_cnt),
        .hold_cnt   (hold_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Write enables as the register file should see them: walk from the
    // youngest lane down, remembering registers already claimed.
    function automatic logic [LANES-1:0] exp_wreg();
        bit [31:0]        seen;
        logic [LANES-1:0] r;
        int               a;
        seen = '0;
        r    = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mem_valid[i] && mem_wreg[i]) begin
                a = int'((mem_wd >> (i * ADDR_W)) & 31);
                if (a != 0 && !seen[a]) r[i] = 1'b1;
                seen[a] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_clear();
        e_valid = '0; e_wdata = '0; e_wd = '0; e_wreg = '0;
        e_whilo = 1'b0; e_hi = '0; e_lo = '0;
    endtask

    task automatic model_edge();
        if (!rst) begin
            model_clear();
            e_bub  = 0;
            e_hold = 0;
        end else if (flush || (stall[4] && !stall[5])) begin
            model_clear();
            if (e_bub < 3) e_bub++;
        end else if (!stall[4]) begin
            e_valid = mem_valid; e_wdata = mem_wdata; e_wd = mem_wd;
            e_wreg  = exp_wreg();
            e_whilo = mem_whilo; e_hi = mem_hi; e_lo = mem_lo;
        end else begin
            if (e_hold < 3) e_hold++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 64'(wb_valid), 64'(e_valid));
        chk({tag, ".wdata"}, 64'(wb_wdata), 64'(e_wdata));
        chk({tag, ".wd"},    64'(wb_wd),    64'(e_wd));
        chk({tag, ".wreg"},  64'(wb_wreg),  64'(e_wreg));
        chk({tag, ".whilo"}, 64'(wb_whilo), 64'(e_whilo));
        chk({tag, ".hi"},    64'(wb_hi),    64'(e_hi));
        chk({tag, ".lo"},    64'(wb_lo),    64'(e_lo));
`ifdef MEM_WB_PERF_EN
        chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(e_bub));
        chk({tag, ".hold_cnt"},   64'(hold_cnt),   64'(e_hold));
`endif
    endtask

    task automatic drive(input logic [5:0] st, input logic fl, input logic [1:0] v,
                         input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1,
                         input logic wh, input logic [31:0] h, input logic [31:0] l);
        stall = st; flush = fl; mem_valid = v; mem_wreg = we;
        mem_wd = {a1, a0}; mem_wdata = {d1, d0};
        mem_whilo = wh; mem_hi = h; mem_lo = l;
    endtask

    task automatic drive_rand();
        logic [5:0] st;
        st    = 6'($urandom);
        st[4] = ($urandom_range(0, 3) == 0);
        drive(st, ($urandom_range(0, 9) == 0), 2'($urandom), 2'($urandom),
              5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
              1'($urandom), $urandom, $urandom);
    endtask

    // One active edge, then compare on the following falling edge.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        e_bub = 0;
        e_hold = 0;
        model_clear();
        rst = 1'b0;
        drive_rand();

        // Reset held with arbitrary inputs.
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            step("reset");
        end
        rst = 1'b1;

        // Normal load.
        drive(6'b0, 1'b0, 2'b11, 2'b11, 5'd3, 32'h11, 5'd4, 32'h22, 1'b0, 32'h0, 32'h0);
        step("load");
        chk("load.wreg_lit", 64'(wb_wreg), 64'h3);
        chk("load.wdata_lit", 64'(wb_wdata), 64'h00000022_00000011);

        // Same destination in both lanes: youngest wins, data kept.
        drive(6'b0, 1'b0, 2'b11, 2'b11, 5'd7, 32'hAA, 5'd7, 32'hBB, 1'b0, 32'h0, 32'h0);
        step("conflict");
        chk("conflict.wreg_lit", 64'(wb_wreg), 64'h2);

        // Write to register 0 suppressed.
        drive(6'b0, 1'b0, 2'b11, 2'b11, 5'd0, 32'h33, 5'd9, 32'h44, 1'b0, 32'h0, 32'h0);
        step("zero_reg");
        chk("zero_reg.wreg_lit", 64'(wb_wreg), 64'h2);

        // MEM stalled, WB running: bubble.
        drive(6'b011111, 1'b0, 2'b11, 2'b11, 5'd5, 32'h55, 5'd6, 32'h66, 1'b1, 32'h1, 32'h2);
        step("bubble");

        // Load, then hold for three cycles, then load again.
        drive(6'b0, 1'b0, 2'b11, 2'b01, 5'd10, 32'h1010, 5'd11, 32'h1111, 1'b1, 32'h9, 32'h8);
        step("preload");
        for (int i = 0; i < 3; i++) begin
            drive(6'b111111, 1'b0, 2'b11, 2'b11, 5'd12, $urandom, 5'd13, $urandom, 1'b0, $urandom, $urandom);
            step("hold");
        end
        drive(6'b0, 1'b0, 2'b10, 2'b10, 5'd14, 32'h1414, 5'd15, 32'h1515, 1'b0, 32'h0, 32'h0);
        step("reload");

        // Flush overrides hold.
        drive(6'b111111, 1'b1, 2'b11, 2'b11, 5'd1, 32'h77, 5'd2, 32'h88, 1'b1, 32'h5, 32'h6);
        step("flush");
        chk("flush.valid_lit", 64'(wb_valid), 64'h0);

        // HI/LO capture.
        drive(6'b0, 1'b0, 2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h1234, 32'h5678);
        step("hilo");
        chk("hilo.hi_lit", 64'(wb_hi), 64'h1234);
        chk("hilo.lo_lit", 64'(wb_lo), 64'h5678);

        // Asynchronous reset in the middle of a hold.
        drive(6'b111111, 1'b0, 2'b11, 2'b11, 5'd3, 32'h1, 5'd4, 32'h2, 1'b1, 32'h3, 32'h4);
        step("hold_pre_rst");
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        e_bub = 0;
        e_hold = 0;
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;

        // Held contents must not reappear; hold counter saturates.
        for (int i = 0; i < 5; i++) begin
            drive(6'b111111, 1'b0, 2'b11, 2'b11, 5'd3, $urandom, 5'd4, $urandom, 1'b1, $urandom, $urandom);
            step("post_rst_hold");
        end
`ifdef MEM_WB_PERF_EN
        chk("hold_cnt_sat", 64'(hold_cnt), 64'h3);
`endif

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            drive_rand();
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_mlane.md
Name: mem_wb_mlane

Overview:
- Parametrised MEM/WB pipeline register for the multi-issue core.
- Captures up to LANES register-file write requests plus one HI/LO write from the MEM stage, presents them to WB one cycle later.
- Honours the 6-bit stall vector, adds an exception flush, and resolves same-cycle write conflicts.
- Filters writes to register 0 before they reach the register file.

Parameters:
- DATA_W, 32, register data width (wdata, hi, lo).
- ADDR_W, 5, register address width.
- LANES, 2, number of write lanes; lane LANES-1 is youngest in program order.
- CNT_W, 16, width of performance counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- stall  in  6  pipeline stall vector; bit 4 = MEM, bit 5 = WB.
- flush  in  1  exception flush; kills the MEM-stage contents this cycle.
- mem_valid  in  LANES  lane i carries a live instruction.
- mem_wdata  in  LANES*DATA_W  lane i write data, lane 0 in LSBs.
- mem_wd  in  LANES*ADDR_W  lane i destination register.
- mem_wreg  in  LANES  lane i write enable.
- mem_whilo  in  1  HI/LO write enable.
- mem_hi  in  DATA_W  HI value.
- mem_lo  in  DATA_W  LO value.
- wb_valid  out  LANES  registered lane valid.
- wb_wdata  out  LANES*DATA_W  registered write data.
- wb_wd  out  LANES*ADDR_W  registered destination.
- wb_wreg  out  LANES  registered, filtered write enable.
- wb_whilo  out  1  registered HI/LO write enable.
- wb_hi  out  DATA_W  registered HI value.
- wb_lo  out  DATA_W  registered LO value.

Behaviour:
- Reset: rst low drives all outputs to zero immediately (asynchronous), without waiting for a clock edge. Zero values are: wdata 0, wd 0 (NOP address), wreg 0, valid 0, whilo 0, hi 0, lo 0. Release is sampled at the next rising edge.
- Per-edge priority, highest first:
  (1) flush=1: load bubble (all zero), regardless of stall.
  (2) stall[4]=1 and stall[5]=0: load bubble.
  (3) stall[4]=0: load filtered MEM inputs.
  (4) stall[4]=1 and stall[5]=1: hold all outputs unchanged.
- Latency: 1 cycle from MEM inputs to WB outputs. There is no combinational path from input to output.
- Lane write filter, applied before capture. The registered wreg for lane i is set only when all of the following hold:
  - mem_valid[i]=1 and mem_wreg[i]=1;
  - mem_wd[i] is not 0;
  - no younger lane j>i has mem_valid[j]=1, mem_wreg[j]=1 and mem_wd[j]=mem_wd[i] (youngest wins).
- A filtered lane still captures wdata, wd and valid unchanged; only wreg is cleared.
- wb_valid[i] = mem_valid[i] on load, 0 on bubble.
- HI/LO: wb_whilo = mem_whilo on load. hi/lo are captured unchanged; there is no lane association.
- Reset asserted mid-hold discards the held contents; there is no replay after release.

Optional Feature:
- Macro: MEM_WB_PERF_EN.
- Defined, two extra outputs are added:
  - bubble_cnt (out, CNT_W): counts edges that load a bubble via rule (1) or (2).
  - hold_cnt (out, CNT_W): counts edges taking rule (4).
  - Both counters saturate at all-ones, reset to 0 asynchronously, and increment one cycle after the qualifying condition is sampled.
- Not defined: the ports and counter logic are absent, and the remaining behaviour is identical.

Decomposition:
- Shared package mem_wb_pkg holds:
  - stall bit indices STALL_MEM=4 and STALL_WB=5;
  - NOP_REG_ADDR=0, ZERO_WORD;
  - a lane write-request struct (wdata, wd, wreg, valid) parameterised via DATA_W/ADDR_W localparams.
- One sub-module is natural: wb_wr_filter, purely combinational, LANES-wide. It performs zero-register suppression and the youngest-wins collapse. Instantiate it once in front of the capture flops.

Test Plan:
- Reset: hold rst=0 with arbitrary inputs, toggle clk. All outputs stay 0, and drop to 0 between edges when rst falls.
- Normal load: LANES=2, lane0 wd=3 data=0x11, lane1 wd=4 data=0x22, both valid/wreg, stall=0. Next cycle wb_wreg=2'b11 with matching data and addresses.
- Conflict: both lanes wd=7 with data 0xAA/0xBB. Expect wb_wreg=2'b10, wb_wdata lane0=0xAA retained, lane1=0xBB. Separately, lane0 wd=0 gives wb_wreg[0]=0.
- Stall: stall=6'b011111 yields a bubble (all zero). stall=6'b111111 holds prior outputs for 3 cycles. Then stall=0 loads new inputs.
- Flush: flush=1 with stall=6'b111111 and live inputs yields a bubble next edge, overriding hold. With MEM_WB_PERF_EN defined, bubble_cnt increments by 1.
- HI/LO: mem_whilo=1, hi=0x1234, lo=0x5678 gives wb_whilo=1, wb_hi=0x1234, wb_lo=0x5678 after one edge. With CNT_W=2 and 5 hold cycles, hold_cnt saturates at 3.
